// File: rtl/seg_pkg.sv
// seg_display_ctrl shared constants: register map,
// CTRL field positions, reset values and hex segment table.
package seg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_BRIGHT = 2'd2;
  localparam logic [1:0] REG_BLINK  = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_LZB   = 1;
  localparam int CTRL_DP    = 8;
  localparam int CTRL_DIGEN = 16;

  localparam logic [31:0] CTRL_RST   = 32'h00FF_0001;
  localparam logic [3:0]  BRIGHT_RST = 4'hF;

  // active-low {g,f,e,d,c,b,a}; entry 0 is the LSB slot
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: 4-bit nibble to active-low
// 7-segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: memory-mapped multiplexed 7-seg scanner.
// Optional per-digit blink via `define SEG_BLINK_EN.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 16000,
  parameter int BLINK_DIV  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           addr,
  input  logic                  wen,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [7:0]            seg_n
);

  localparam int SLICE_LEN = SCAN_DIV / 16;
  localparam int SUB_W =
    (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;
  localparam int DIG_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MASK64 =
    (64'h1 << (4 * NUM_DIGITS)) - 64'h1;
  localparam logic [31:0] DATA_MASK = MASK64[31:0];

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 ||
      SCAN_DIV < 16 || (SCAN_DIV % 16) != 0 ||
      BLINK_DIV < 1) begin : g_cfg_err
    $error("seg_display_ctrl: bad parameters");
  end

  logic [SUB_W-1:0] sub;
  logic [3:0]       slice;
  logic [DIG_W-1:0] dig;
  logic             run;

  logic [31:0] data;
  logic        en;
  logic        lzb;
  logic [7:0]  dp;
  logic [7:0]  digen;
  logic [3:0]  bright;

  logic hit;
  logic last_sub;
  logic last_dwell;
  logic last_frame;
  logic blink_off;
  logic lit;
  logic [31:0] hi_bits;
  logic [6:0]  hex_seg;
  logic        unused_ok;

  assign hit        = (addr[11:4] == 8'h00);
  assign last_sub   = (sub == SUB_W'(SLICE_LEN - 1));
  assign last_dwell = last_sub && (slice == 4'hF);
  assign last_frame =
    last_dwell && (dig == DIG_W'(NUM_DIGITS - 1));
  assign unused_ok  = ^{addr[1:0], wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub   <= '0;
      slice <= '0;
      dig   <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      sub <= last_sub ? '0 : sub + 1'b1;
      if (last_sub)
        slice <= slice + 4'd1;
      if (last_dwell)
        dig <= last_frame ? '0 : dig + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      en     <= CTRL_RST[CTRL_EN];
      lzb    <= CTRL_RST[CTRL_LZB];
      dp     <= CTRL_RST[CTRL_DP +: 8];
      digen  <= CTRL_RST[CTRL_DIGEN +: 8];
      bright <= BRIGHT_RST;
    end else if (wen && hit) begin
      case (addr[3:2])
        REG_DATA: data <= wdata & DATA_MASK;
        REG_CTRL: begin
          en    <= wdata[CTRL_EN];
          lzb   <= wdata[CTRL_LZB];
          dp    <= wdata[CTRL_DP +: 8];
          digen <= wdata[CTRL_DIGEN +: 8];
        end
        REG_BRIGHT: bright <= wdata[3:0];
        default: ;
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FR_W =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [NUM_DIGITS-1:0] blink;
  logic [FR_W-1:0]       frame_cnt;
  logic                  phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink     <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (wen && hit && addr[3:2] == REG_BLINK)
        blink <= wdata[NUM_DIGITS-1:0];
      if (last_frame) begin
        if (frame_cnt == FR_W'(BLINK_DIV - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_off = blink[dig] && phase;
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (addr[3:2])
        REG_DATA: rdata = data;
        REG_CTRL: begin
          rdata[CTRL_EN]         = en;
          rdata[CTRL_LZB]        = lzb;
          rdata[CTRL_DP +: 8]    = dp;
          rdata[CTRL_DIGEN +: 8] = digen;
        end
        REG_BRIGHT: rdata[3:0] = bright;
`ifdef SEG_BLINK_EN
        REG_BLINK: rdata[NUM_DIGITS-1:0] = blink;
`endif
        default: rdata = '0;
      endcase
    end
  end

  // nibble of the scanned digit and everything above it
  assign hi_bits = data >> {dig, 2'b00};

  seg_hex_decoder u_hex (
    .nib (hi_bits[3:0]),
    .seg (hex_seg)
  );

  // last cycle of every dwell stays dark so digits never overlap
  assign lit = run && en && digen[dig] &&
               (slice <= bright) && !last_dwell &&
               !(lzb && dig != '0 && hi_bits == '0) &&
               !blink_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en <= '1;
      seg_n  <= 8'hFF;
    end else if (lit) begin
      led_en <= ~(NUM_DIGITS'(1) << dig);
      seg_n  <= {~dp[dig], hex_seg};
    end else begin
      led_en <= '1;
      seg_n  <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: register vector table, per-cycle
// scan scoreboard and hand sequences for reset/PWM/blink.
module tb_seg_display_ctrl;

  localparam int ND   = 8;
  localparam int SD   = 64;
  localparam int BD   = 2;
  localparam int FRM  = SD * ND;

  logic        clk;
  logic        rst;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led_en;
  logic [7:0]  seg_n;

  seg_display_ctrl #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wen    (wen),
    .wdata  (wdata),
    .rdata  (rdata),
    .led_en (led_en),
    .seg_n  (seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int edges;
  bit mon_on = 0;
  logic [15:0] q[$];

  logic [31:0] s_data;
  logic [31:0] s_ctrl;
  logic [3:0]  s_bright;
  logic [7:0]  s_blink;

  typedef struct {
    string       name;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[9];

  function automatic logic [6:0] hexs(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;
      4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;
      4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;
      4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [15:0] model(input int pos,
                                        input bit run);
    int d, w, sl;
    logic [31:0] hi;
    logic on;
    logic [7:0] led;
    d  = (pos / SD) % ND;
    w  = pos % SD;
    sl = w / (SD / 16);
    hi = s_data >> (4 * d);
    on = run && s_ctrl[0] && s_ctrl[16 + d] &&
         (sl <= int'(s_bright)) && (w != SD - 1);
    if (s_ctrl[1] && d != 0 && hi == 0) on = 1'b0;
`ifdef SEG_BLINK_EN
    if (s_blink[d] && ((pos / FRM / BD) % 2 == 1))
      on = 1'b0;
`endif
    led = 8'hFF;
    if (!on) return 16'hFFFF;
    led[d] = 1'b0;
    return {led, ~s_ctrl[8 + d], hexs(hi[3:0])};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  always @(negedge clk) begin
    logic [15:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({led_en, seg_n} !== e) begin
        fails++;
        if (fails <= 20)
          $display("FAIL scan t=%0t got led_en=%h seg_n=%h want %h %h",
                   $time, led_en, seg_n, e[15:8], e[7:0]);
      end
    end
    if (mon_on && !rst)
      q.push_back(model(edges, edges >= 1));
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic shadow_reset();
    s_data   = 32'h0;
    s_ctrl   = 32'h00FF_0001;
    s_bright = 4'hF;
    s_blink  = 8'h00;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = 1'b1;
    @(posedge clk);
    #1;
    wen = 1'b0;
    if (a[11:4] == 8'h0) begin
      case (a[3:2])
        2'd0: s_data   = d;
        2'd1: s_ctrl   = d & 32'h00FF_FF03;
        2'd2: s_bright = d[3:0];
        default: begin
`ifdef SEG_BLINK_EN
          s_blink = d[7:0];
`endif
        end
      endcase
    end
  endtask

  task automatic rd(input string nm, input logic [11:0] a,
                    input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic wait_led(input string nm, input logic [7:0] p);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * FRM && !ok; i++) begin
      @(negedge clk);
      if (led_en == p) ok = 1;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s timeout waiting led_en=%h got=%h",
               nm, p, led_en);
    end
  endtask

  task automatic count_lit(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led_en != 8'hFF) c++;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1;
    @(posedge clk);
    #1;
    chk("rel_edge1", {led_en, seg_n}, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("rel_edge2", {led_en, seg_n}, 16'hFEC0);
  endtask

  initial begin
    int c;
    rst = 1'b1; wen = 1'b0; addr = '0; wdata = '0;
    shadow_reset();
    vecs[0] = '{"data_rw",     12'h000, 32'h1234ABCD, 12'h000, 32'h1234ABCD};
    vecs[1] = '{"ctrl_mask",   12'h004, 32'hFFFFFFFF, 12'h004, 32'h00FFFF03};
    vecs[2] = '{"bright_mask", 12'h008, 32'hFFFFFFF3, 12'h008, 32'h00000003};
    vecs[3] = '{"unmap_wr",    12'h010, 32'hDEADBEEF, 12'h000, 32'h1234ABCD};
    vecs[4] = '{"unmap_rd",    12'h100, 32'h00000000, 12'h100, 32'h00000000};
`ifdef SEG_BLINK_EN
    vecs[5] = '{"blink_reg",   12'h00C, 32'hFFFFFFA5, 12'h00C, 32'h000000A5};
`else
    vecs[5] = '{"blink_reg",   12'h00C, 32'hFFFFFFA5, 12'h00C, 32'h00000000};
`endif
    vecs[6] = '{"addr_lsb",    12'h007, 32'h00FF0001, 12'h006, 32'h00FF0001};
    vecs[7] = '{"bright_lsb",  12'h008, 32'h0000000F, 12'h00B, 32'h0000000F};
    vecs[8] = '{"blink_clr",   12'h00C, 32'h00000000, 12'h00C, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {led_en, seg_n}, 16'hFFFF);
    rd("rst_data",   12'h000, 32'h0);
    rd("rst_ctrl",   12'h004, 32'h00FF0001);
    rd("rst_bright", 12'h008, 32'h0000000F);
    rd("rst_blink",  12'h00C, 32'h0);
    release_rst();
    repeat (FRM + 8) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    wait_led("d0_wait", 8'hFE);
    chk("d0_hex_d", {24'h0, seg_n}, 32'hA1);
    wait_led("d7_wait", 8'h7F);
    chk("d7_hex_1", {24'h0, seg_n}, 32'hF9);

    wr(12'h004, 32'h00FF0003);
    wr(12'h000, 32'h00000050);
    repeat (2) @(negedge clk);
    wait_led("lzb_d0_wait", 8'hFE);
    chk("lzb_d0", {24'h0, seg_n}, 32'hC0);
    wait_led("lzb_d1_wait", 8'hFD);
    chk("lzb_d1", {24'h0, seg_n}, 32'h92);
    c = 0;
    for (int i = 0; i < FRM; i++) begin
      @(negedge clk);
      if (led_en[7:2] != 6'h3F) c++;
    end
    chk("lzb_hi_dark", c, 0);

    wr(12'h004, 32'h00FF0001);
    wr(12'h008, 32'h3);
    repeat (2) @(negedge clk);
    count_lit(FRM, c);
    chk("pwm_l3", c, 8 * 16);
    wr(12'h008, 32'h0);
    repeat (2) @(negedge clk);
    count_lit(FRM, c);
    chk("pwm_l0", c, 8 * 4);
    wr(12'h008, 32'hF);
    repeat (2) @(negedge clk);
    count_lit(FRM, c);
    chk("pwm_l15", c, 8 * (SD - 1));

    wait_led("d5_wait", 8'hDF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mon_on = 0;
    q.delete();
    #1;
    chk("rst_async", {led_en, seg_n}, 16'hFFFF);
    shadow_reset();
    repeat (3) @(posedge clk);
    rd("rst2_data", 12'h000, 32'h0);
    rd("rst2_ctrl", 12'h004, 32'h00FF0001);
    release_rst();

`ifdef SEG_BLINK_EN
    wr(12'h00C, 32'h1);
    while (edges < FRM + 1) @(negedge clk);
    c = 0;
    while (edges < 2 * FRM + 1) begin
      if (led_en == 8'hFE) c++;
      @(negedge clk);
    end
    chk("blink_f1_lit", c, SD - 1);
    c = 0;
    while (edges < 4 * FRM + 1) begin
      if (led_en == 8'hFE) c++;
      @(negedge clk);
    end
    chk("blink_f23_dark", c, 0);
    c = 0;
    while (edges < 6 * FRM + 1) begin
      if (led_en == 8'hFE) c++;
      @(negedge clk);
    end
    chk("blink_f45_lit", c, 2 * (SD - 1));
`else
    repeat (FRM) @(negedge clk);
`endif

    mon_on = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
